// File: rtl/checker_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// checker_ctrl_pkg
//   Shared definitions for the checker control stage: the FSM state encoding
//   and the blanking count applied after a run is started.
// ----------------------------------------------------------------------------
package checker_ctrl_pkg;

  // Controller states. The 2-bit encoding is fixed so the state can be
  // exported to a status register without translation.
  typedef enum logic [1:0] {
    CHECKER_CTRL_STATE_IDLE = 2'd0,
    CHECKER_CTRL_STATE_ARM  = 2'd1,
    CHECKER_CTRL_STATE_RUN  = 2'd2,
    CHECKER_CTRL_STATE_HOLD = 2'd3
  } state_t;

  // Cycles spent in ARM before mode_end/mode_error are trusted. The checker
  // needs this long to clear the level flags left over from the last run.
  localparam logic [1:0] CHECKER_CTRL_BLANK = 2'd2;

  // Width of the checker interrupt words.
  localparam int CHECKER_CTRL_DW = 64;

endpackage : checker_ctrl_pkg

// File: rtl/checker_fifo.sv
// ----------------------------------------------------------------------------
// checker_fifo
//   Synchronous first-word-fall-through FIFO holding checker interrupt words
//   for host readout. The head word is registered so dout is a clean flop
//   output that reads 0 after reset and while the FIFO is empty.
//
//   Ports
//     sys_clk  in   clock
//     sys_rst  in   synchronous active-high reset (empties the FIFO)
//     we       in   push request; accepted when not full or when popping
//     din      in   word to push
//     re       in   pop request; ignored when empty
//     dout     out  head word (valid while !empty)
//     empty    out  no words stored
//     full     out  2**aw words stored
//     level    out  number of stored words
// ----------------------------------------------------------------------------
module checker_fifo
  import checker_ctrl_pkg::*;
#(
  parameter int aw = 3
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       we,
  input  logic [CHECKER_CTRL_DW-1:0] din,
  input  logic                       re,
  output logic [CHECKER_CTRL_DW-1:0] dout,
  output logic                       empty,
  output logic                       full,
  output logic [aw:0]                level
);

  localparam int depth = 1 << aw;

  logic [CHECKER_CTRL_DW-1:0] mem [depth];
  logic [aw-1:0]              wr_ptr;
  logic [aw-1:0]              rd_ptr;
  logic [aw-1:0]              rd_ptr_next;
  logic [aw:0]                count;
  logic [CHECKER_CTRL_DW-1:0] dout_q;
  logic                       do_push;
  logic                       do_pop;

  assign empty = (count == '0);
  assign full  = (count == (aw + 1)'(depth));
  assign level = count;
  assign dout  = dout_q;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign do_pop      = re && !empty;
  assign do_push     = we && (!full || do_pop);
  assign rd_ptr_next = rd_ptr + aw'(1);

  // NOTE: the storage array has no reset; only pointers, count and the head
  // register do. Every word is written before it can reach dout, so clearing
  // the array would only cost a reset net on every bit.
  always_ff @(posedge sys_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + aw'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr_next;
      end

      case ({do_push, do_pop})
        2'b10:   count <= count + (aw + 1)'(1);
        2'b01:   count <= count - (aw + 1)'(1);
        default: count <= count;
      endcase

      // Head register: after a pop it takes the next stored word, or the
      // word arriving this cycle if the FIFO held only one entry, or 0 if
      // the FIFO runs dry. A push into an empty FIFO falls straight through.
      if (do_pop) begin
        if (count > (aw + 1)'(1)) begin
          dout_q <= mem[rd_ptr_next];
        end else if (do_push) begin
          dout_q <= din;
        end else begin
          dout_q <= '0;
        end
      end else if (do_push && empty) begin
        dout_q <= din;
      end
    end
  end

endmodule : checker_fifo

// File: rtl/checker_ctrl.sv
// ----------------------------------------------------------------------------
// checker_ctrl
//   Control stage in front of the per-mode checkers. Converts host start/stop
//   pulses into the level-sensitive mode_* run protocol, drains checker IRQ
//   words into a FIFO, withholds mode_ack while the FIFO is full, and reports
//   run completion/error to the host.
//
//   Ports
//     sys_clk, sys_rst      clock, synchronous active-high reset
//     csr_mode, csr_addr    run parameters, captured on an accepted start
//     csr_start, csr_stop   one-cycle host requests
//     mode_mode, mode_addr  run parameters held towards the checker
//     mode_start            run level towards the checker
//     mode_end, mode_error  terminal levels from the selected checker
//     mode_irq, mode_data   one-cycle word strobe and its data
//     mode_ack              one-cycle acknowledge of a consumed word
//     fifo_re               host pop
//     fifo_dout/empty/full/level  FIFO head word and status
//     stat_busy             run in progress
//     stat_done/stat_error  sticky outcome of the last run
//     irq                   one-cycle host interrupt
// ----------------------------------------------------------------------------
module checker_ctrl
  import checker_ctrl_pkg::*;
#(
  parameter int fifo_aw = 3
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [1:0]                 csr_mode,
  input  logic [63:0]                csr_addr,
  input  logic                       csr_start,
  input  logic                       csr_stop,
  output logic [1:0]                 mode_mode,
  output logic                       mode_start,
  output logic [63:0]                mode_addr,
  input  logic                       mode_end,
  input  logic [63:0]                mode_data,
  input  logic                       mode_irq,
  output logic                       mode_ack,
  input  logic                       mode_error,
  input  logic                       fifo_re,
  output logic [63:0]                fifo_dout,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic [fifo_aw:0]           fifo_level,
  output logic                       stat_busy,
  output logic                       stat_done,
  output logic                       stat_error,
  output logic                       irq
);

  state_t      state_q, state_d;
  logic [1:0]  blank_q, blank_d;
  logic [1:0]  mode_q;
  logic [63:0] addr_q;
  logic        start_q, start_d;
  logic        ack_q, ack_d;
  logic        irq_q, irq_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        latch;
  logic        push;
  logic        term;
  logic        room;

  // A word can be taken when there is space now or a host pop frees a slot
  // in the same cycle.
  assign room = !fifo_full || fifo_re;

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  // NOTE: every signal driven here gets its default before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    blank_d = blank_q;
    start_d = start_q;
    done_d  = done_q;
    err_d   = err_q;
    ack_d   = 1'b0;
    latch   = 1'b0;
    push    = 1'b0;
    term    = 1'b0;

    case (state_q)
      CHECKER_CTRL_STATE_IDLE: begin
        // Start and stop together is treated as no request at all.
        if (csr_start && !csr_stop) begin
          state_d = CHECKER_CTRL_STATE_ARM;
          latch   = 1'b1;
          start_d = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          blank_d = CHECKER_CTRL_BLANK;
        end
      end

      CHECKER_CTRL_STATE_ARM: begin
        // mode_end/mode_error may still show the previous run here, so they
        // are not looked at until the blanking count expires.
        if (csr_stop) begin
          state_d = CHECKER_CTRL_STATE_IDLE;
          start_d = 1'b0;
        end else begin
          blank_d = blank_q - 2'd1;
          if (blank_q <= 2'd1) begin
            state_d = CHECKER_CTRL_STATE_RUN;
          end
        end
      end

      CHECKER_CTRL_STATE_RUN: begin
        if (csr_stop) begin
          state_d = CHECKER_CTRL_STATE_IDLE;
          start_d = 1'b0;
        end else if (mode_error) begin
          state_d = CHECKER_CTRL_STATE_IDLE;
          start_d = 1'b0;
          err_d   = 1'b1;
          term    = 1'b1;
        end else if (mode_end) begin
          state_d = CHECKER_CTRL_STATE_IDLE;
          start_d = 1'b0;
          done_d  = 1'b1;
          term    = 1'b1;
        end else if (mode_irq) begin
          if (room) begin
            push  = 1'b1;
            ack_d = 1'b1;
          end else begin
            // No ack: the checker keeps mode_data stable until we take it.
            state_d = CHECKER_CTRL_STATE_HOLD;
          end
        end
      end

      CHECKER_CTRL_STATE_HOLD: begin
        if (csr_stop) begin
          // The checker is blocked waiting for an ack, so it must get one
          // even though the pending word is dropped.
          state_d = CHECKER_CTRL_STATE_IDLE;
          start_d = 1'b0;
          ack_d   = 1'b1;
        end else if (room) begin
          state_d = CHECKER_CTRL_STATE_RUN;
          push    = 1'b1;
          ack_d   = 1'b1;
        end
      end
    endcase

    irq_d = term || (push && fifo_empty);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= CHECKER_CTRL_STATE_IDLE;
      blank_q <= '0;
      mode_q  <= '0;
      addr_q  <= '0;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      irq_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blank_q <= blank_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      irq_q   <= irq_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (latch) begin
        mode_q <= csr_mode;
        addr_q <= csr_addr;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Word FIFO
  // --------------------------------------------------------------------------
  checker_fifo #(
    .aw (fifo_aw)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .we      (push),
    .din     (mode_data),
    .re      (fifo_re),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  assign mode_mode  = mode_q;
  assign mode_addr  = addr_q;
  assign mode_start = start_q;
  assign mode_ack   = ack_q;
  assign irq        = irq_q;
  assign stat_done  = done_q;
  assign stat_error = err_q;
  assign stat_busy  = (state_q != CHECKER_CTRL_STATE_IDLE);

endmodule : checker_ctrl
